// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD lane-wise accumulation controller.
// Contents: lane mode codes, controller state encoding and lane widths.
// Imported by simd_mode_dec and simd_acc_ctrl.
package simd_pkg;

    // Lane mode codes as carried on in_mode / out_mode. Code 2'b11 is decoded as MODE_Q.
    localparam logic [1:0] MODE_H = 2'b00;  // one 16-bit lane
    localparam logic [1:0] MODE_O = 2'b01;  // two 8-bit lanes
    localparam logic [1:0] MODE_Q = 2'b10;  // four 4-bit lanes

    // Width of a single lane in each mode.
    localparam int LANE_W_H = 16;
    localparam int LANE_W_O = 8;
    localparam int LANE_W_Q = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/simd_mode_dec.sv
// Decodes a 2-bit lane mode into the one-hot {h,o,q} lines the SIMD adder expects.
// Ports: mode_i (mode code in), h_o / o_o / q_o (one-hot lane select out).
// Pure combinational; code 2'b11 falls into the 4x4 lane mode.
module simd_mode_dec
    import simd_pkg::*;
(
    input  logic [1:0] mode_i,
    output logic       h_o,
    output logic       o_o,
    output logic       q_o
);

    always_comb begin
        h_o = (mode_i == MODE_H);
        o_o = (mode_i == MODE_O);
        // Both 2'b10 and the spare 2'b11 select the 4-bit lanes.
        q_o = mode_i[1];
    end

endmodule

// File: rtl/simd_acc_ctrl.sv
// Lane-wise accumulation controller around a combinational SIMD add/sub unit.
// Ports: clk/rst; in_valid/in_ready/in_data/in_mode/in_sub operand stream;
//        add_* adder drive and add_sum return; out_valid/out_ready/out_data/out_mode result stream.
// A burst of BEATS vectors is summed into the accumulator; the result is held until
// out_ready, and a new burst may start in the same cycle the result is taken.
module simd_acc_ctrl
    import simd_pkg::*;
#(
    parameter int BEATS = 4,  // vectors per burst, 1..255
    parameter int CNT_W = 8   // beat counter width, 2**CNT_W > BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_mode,
    input  logic        in_sub,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_h,
    output logic        add_o,
    output logic        add_q,
    output logic        add_sub,
    input  logic [15:0] add_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_mode
);

    // Counter value of the final beat of a burst while in ACCUM.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_t             state_q;
    logic [15:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         mode_q;
    logic               out_valid_q;
    logic [15:0]        out_data_q;
    logic [1:0]         out_mode_q;

    logic               beat_acc;
    logic [1:0]         dec_mode;

    // Holding a result blocks new beats unless the consumer takes it this cycle.
    assign in_ready = (state_q != HOLD) || out_ready;
    assign beat_acc = in_valid && in_ready;
    assign cnt_d    = cnt_q + CNT_W'(1);

    // First beat of a burst (IDLE or HOLD) adds to zero, so the accumulator never
    // needs a separate clear cycle between bursts.
    assign add_a   = (state_q == ACCUM) ? acc_q : 16'h0000;
    assign add_b   = in_data;
    assign add_sub = in_sub;

    // Mid-burst the latched mode drives the adder so in_mode changes are ignored.
    assign dec_mode = (state_q == ACCUM) ? mode_q : in_mode;

    simd_mode_dec u_mode_dec (
        .mode_i (dec_mode),
        .h_o    (add_h),
        .o_o    (add_o),
        .q_o    (add_q)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            mode_q      <= MODE_H;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_mode_q  <= MODE_H;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (beat_acc) begin
                        // Start of a burst; in HOLD this coincides with the result handoff.
                        mode_q <= in_mode;
                        acc_q  <= add_sum;
                        cnt_q  <= CNT_W'(1);
                        if (BEATS == 1) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                            out_data_q  <= add_sum;
                            out_mode_q  <= in_mode;
                        end else begin
                            state_q     <= ACCUM;
                            out_valid_q <= 1'b0;
                        end
                    end else if ((state_q == HOLD) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                ACCUM: begin
                    if (beat_acc) begin
                        acc_q <= add_sum;
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                            out_data_q  <= add_sum;
                            out_mode_q  <= mode_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
